// File: rtl/uart_tx_buf.sv
// uart_tx_buf: byte FIFO followed by a UART transmitter. Edge-pixel bytes arrive as
// one-cycle strobes, are buffered, and are sent as 8N1 frames (LSB first) on tx.
//
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit between the
// data bits and the stop bit (8E1, 11 bit periods per frame).
//
// Ports:
//   sys_clk    system clock, rising edge
//   sys_rst_n  asynchronous active-low reset
//   pi_data    byte to transmit
//   pi_flag    one-cycle write strobe for pi_data
//   tx         serial output, idle high, registered
//   tx_busy    high while a frame is on the line, registered
//   fifo_cnt   FIFO occupancy, 0..FIFO_DEPTH
//   overflow   sticky: a byte was dropped because the FIFO was full
module uart_tx_buf #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int UART_BPS   = 9600,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst_n,
  input  logic [7:0]                  pi_data,
  input  logic                        pi_flag,
  output logic                        tx,
  output logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_cnt,
  output logic                        overflow
);

  localparam int CW           = $clog2(FIFO_DEPTH) + 1;
  localparam int PW           = $clog2(FIFO_DEPTH);
  localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
  localparam int BW           = $clog2(BAUD_CNT_MAX + 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0, ST_START = 3'd1, ST_DATA = 3'd2, ST_PARITY = 3'd3, ST_STOP = 3'd4
  } state_t;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0, ST_START = 2'd1, ST_DATA = 2'd2, ST_STOP = 2'd3
  } state_t;
`endif

  // FIFO storage and bookkeeping
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          full_s, wr_en_s, pop_s;
  logic [7:0]    head_s;

  // Transmitter state
  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          baud_last_s;
`ifdef UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  // Fullness is judged on the pre-pop count, so a pop on the same edge cannot make room.
  assign full_s      = (cnt_q == CW'(FIFO_DEPTH));
  assign wr_en_s     = pi_flag & ~full_s;
  assign head_s      = mem_q[rd_ptr_q];
  assign baud_last_s = (baud_q == BW'(BAUD_CNT_MAX - 1));

  // FIFO storage write port (no reset needed on the array)
  always_ff @(posedge sys_clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q] <= pi_data;
    end
  end

  // FIFO pointer, occupancy and overflow next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    if (wr_en_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_en_s, pop_s})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    if (pi_flag && full_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Transmitter next-state; tx_d is the line level for the state being entered
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop_s   = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cnt_q != CW'(0)) begin
          pop_s   = 1'b1;
          shift_d = head_s;
`ifdef UART_TX_PARITY_EN
          par_d   = even_parity(head_s);
`endif
          state_d = ST_START;
          baud_d  = BW'(0);
          tx_d    = 1'b0;
        end else begin
          tx_d    = 1'b1;
        end
      end
      ST_START: begin
        if (baud_last_s) begin
          state_d = ST_DATA;
          baud_d  = BW'(0);
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
        end else begin
          baud_d  = baud_q + BW'(1);
        end
      end
      ST_DATA: begin
        if (baud_last_s) begin
          baud_d = BW'(0);
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
            tx_d    = par_q;
`else
            state_d = ST_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            // Shift right so the next bit to send is always at shift_q[0]
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (baud_last_s) begin
          state_d = ST_STOP;
          baud_d  = BW'(0);
          tx_d    = 1'b1;
        end else begin
          baud_d  = baud_q + BW'(1);
        end
      end
`endif
      ST_STOP: begin
        if (baud_last_s) begin
          baud_d = BW'(0);
          // Chain straight into the next frame when data is waiting
          if (cnt_q != CW'(0)) begin
            pop_s   = 1'b1;
            shift_d = head_s;
`ifdef UART_TX_PARITY_EN
            par_d   = even_parity(head_s);
`endif
            state_d = ST_START;
            tx_d    = 1'b0;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        baud_d  = BW'(0);
        bit_d   = 3'd0;
        tx_d    = 1'b1;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State registers for FIFO bookkeeping and transmitter
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr_q <= PW'(0);
      rd_ptr_q <= PW'(0);
      cnt_q    <= CW'(0);
      ovf_q    <= 1'b0;
      state_q  <= ST_IDLE;
      baud_q   <= BW'(0);
      bit_q    <= 3'd0;
      shift_q  <= 8'h00;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
`ifdef UART_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  assign tx       = tx_q;
  assign tx_busy  = busy_q;
  assign fifo_cnt = cnt_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx_buf.sv
// Testbench for uart_tx_buf. A queue-based reference model predicts FIFO occupancy,
// overflow, busy and the tx line every cycle; popped bytes are pushed to a scoreboard
// that an independent UART receiver process decodes against.
module tb_uart_tx_buf;

  localparam int CLK_FREQ = 1_000_000;
  localparam int UART_BPS = 100_000;
  localparam int BAUD     = CLK_FREQ / UART_BPS;
  localparam int DEPTH    = 16;
  localparam int CW       = $clog2(DEPTH) + 1;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS    = 11;
`else
  localparam int NBITS    = 10;
`endif
  localparam int FRAME    = NBITS * BAUD;

  logic          sys_clk   = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic          pi_flag   = 1'b0;
  logic [7:0]    pi_data   = 8'h00;
  logic          tx, tx_busy, overflow;
  logic [CW-1:0] fifo_cnt;

  uart_tx_buf #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .FIFO_DEPTH(DEPTH)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pi_data(pi_data), .pi_flag(pi_flag),
    .tx(tx), .tx_busy(tx_busy), .fifo_cnt(fifo_cnt), .overflow(overflow)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0] m_q[$];      // bytes waiting in the FIFO
  logic [7:0] exp_q[$];    // bytes popped, awaiting decode on the line
  logic       m_ovf = 1'b0;
  int         k = 0;       // edge index
  int         last_pop = -FRAME;
  logic [7:0] last_byte = 8'h00;
  int         rst_epoch = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, k, act, exp);
    end
  endtask

  // Line level t clocks into a frame carrying byte b
  function automatic int exp_tx(input int t, input logic [7:0] b);
    int idx;
    idx = t / BAUD;
    if (idx == 0) return 0;
    else if (idx <= 8) return int'(b[idx-1]);
    else if (idx == 9 && NBITS == 11) return int'(^b);
    else return 1;
  endfunction

  // Apply the buffering rules for one rising edge: the transmitter may take a byte
  // whenever the previous frame has fully elapsed; fullness uses the pre-pop size.
  task automatic model_edge();
    bit do_wr;
    if (sys_rst_n) begin
      do_wr = pi_flag && (m_q.size() < DEPTH);
      if (pi_flag && !do_wr) m_ovf = 1'b1;
      if (m_q.size() > 0 && k >= last_pop + FRAME) begin
        last_byte = m_q.pop_front();
        exp_q.push_back(last_byte);
        last_pop = k;
      end
      if (do_wr) m_q.push_back(pi_data);
    end
  endtask

  task automatic step();
    bit busy;
    @(posedge sys_clk);
    model_edge();
    #1;
    busy = (k < last_pop + FRAME);
    chk("fifo_cnt", int'(fifo_cnt), m_q.size());
    chk("overflow", int'(overflow), int'(m_ovf));
    chk("tx_busy", int'(tx_busy), int'(busy));
    chk("tx", int'(tx), busy ? exp_tx(k - last_pop, last_byte) : 1);
    k++;
  endtask

  task automatic send(input logic [7:0] d);
    pi_flag = 1'b1;
    pi_data = d;
    step();
    pi_flag = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((m_q.size() > 0 || k < last_pop + FRAME + BAUD) && guard < 5000) begin
      step();
      guard++;
    end
    chk("drain_timeout", int'(guard < 5000), 1);
  endtask

  // Reset asserted between clock edges: outputs must change without waiting for a clock
  task automatic async_reset();
    #2;
    sys_rst_n = 1'b0;
    rst_epoch++;
    m_q.delete();
    exp_q.delete();
    m_ovf = 1'b0;
    last_pop = k - FRAME;
    #1;
    chk("rst_tx", int'(tx), 1);
    chk("rst_busy", int'(tx_busy), 0);
    chk("rst_cnt", int'(fifo_cnt), 0);
    chk("rst_ovf", int'(overflow), 0);
    idle(3);
    sys_rst_n = 1'b1;
  endtask

  // Receiver: finds a start bit, samples every bit at its centre, checks the scoreboard
  initial begin
    logic [7:0] d;
    logic       s0, p, sp;
    logic [7:0] e;
    int         ep;
    forever begin
      @(negedge sys_clk);
      if (sys_rst_n && tx == 1'b0) begin
        ep = rst_epoch;
        p  = 1'b0;
        repeat (BAUD / 2) @(negedge sys_clk);
        s0 = tx;
        for (int i = 0; i < 8; i++) begin
          repeat (BAUD) @(negedge sys_clk);
          d[i] = tx;
        end
        if (NBITS == 11) begin
          repeat (BAUD) @(negedge sys_clk);
          p = tx;
        end
        repeat (BAUD) @(negedge sys_clk);
        sp = tx;
        if (ep == rst_epoch && sys_rst_n) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rx_unexpected: got byte %0h expected none", d);
          end else begin
            e = exp_q.pop_front();
            chk("rx_start", int'(s0), 0);
            chk("rx_byte", int'(d), int'(e));
            if (NBITS == 11) chk("rx_parity", int'(p), int'(^e));
            chk("rx_stop", int'(sp), 1);
          end
        end
      end
    end
  end

  initial begin
    idle(3);
    sys_rst_n = 1'b1;
    idle(2);

    // Single byte from idle
    send(8'hA5);
    idle(FRAME + 10);

    // Back-to-back frames
    send(8'h00);
    send(8'hFF);
    send(8'h3C);
    drain();

    // Burst past FIFO capacity
    for (int i = 0; i < 20; i++) send(8'(i));
    drain();

    // Write coinciding with the stop-end pop while one byte is queued
    send(8'h11);
    send(8'h22);
    idle(FRAME - 1);
    send(8'h33);
    drain();

    // Reset in the middle of a frame, then a clean frame
    send(8'h81);
    idle(4 * BAUD);
    async_reset();
    idle(60);
    send(8'h55);
    drain();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 14) == 0) send(8'($urandom));
      else step();
    end
    drain();
    idle(20);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_buf.md
Name: uart_tx_buf

Overview:
Downstream stage of the Sobel edge-detection pipeline. Accepts the binary edge-pixel byte stream (8-bit data plus a one-cycle valid flag) and buffers it in an internal synchronous FIFO. Drains the FIFO as 8N1 UART frames on a single serial line toward the host PC. Absorbs the bursty line-rate output of the filter against the much slower serial link.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
UART_BPS, 9600, serial bit rate; BAUD_CNT_MAX = CLK_FREQ/UART_BPS clocks per bit (integer division)
FIFO_DEPTH, 16, FIFO entries; power of two, >= 2
CW, $clog2(FIFO_DEPTH)+1, width of fifo_cnt (derived localparam-style, not overridden)

Ports:
sys_clk  input  1  system clock, all logic on rising edge
sys_rst_n  input  1  reset, asynchronous assert, active-low
pi_data  input  8  pixel byte to transmit
pi_flag  input  1  one-cycle write strobe for pi_data
tx  output  1  UART serial output, idle high
tx_busy  output  1  high while a frame is on the line (START..STOP)
fifo_cnt  output  CW  current FIFO occupancy, 0..FIFO_DEPTH
overflow  output  1  sticky flag: a byte was dropped because the FIFO was full

Behaviour:
- Reset (sys_rst_n low, async): tx=1, tx_busy=0, fifo_cnt=0, overflow=0, state=IDLE, baud and bit counters=0, FIFO pointers=0. Deassertion mid-frame aborts the frame; tx stays high.
- FIFO write: on pi_flag=1 and fifo_cnt<FIFO_DEPTH, store pi_data; fifo_cnt increments at that edge.
- Full: pi_flag=1 with fifo_cnt==FIFO_DEPTH drops the byte and sets overflow; overflow stays set until reset. Fullness is judged before any pop in the same cycle, so a write and a pop on the same edge while full still drop the write.
- Simultaneous write and pop when not full: fifo_cnt is unchanged and both happen.
- Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if fifo_cnt>0, pop the head byte into the shift register, go to START, and drive tx=0 at the same edge. Otherwise hold tx=1.
  - START: one bit period (BAUD_CNT_MAX clocks), then DATA.
  - DATA: 8 bits, LSB first, each held for BAUD_CNT_MAX clocks; a bit counter runs 0..7, then STOP.
  - STOP: tx=1 for one bit period. On its last clock, if fifo_cnt>0, pop and go directly to START with no idle gap; else go to IDLE.
- Baud counter runs 0..BAUD_CNT_MAX-1 and clears on every state change.
- tx is a registered output; there are no combinational paths from inputs to outputs.
- Latency: a pi_flag in cycle N, with the block idle and the FIFO empty, drives tx low starting in cycle N+2. The frame lasts 10*BAUD_CNT_MAX clocks.
- tx_busy is 1 in START, DATA and STOP, and 0 in IDLE.

Optional Feature:
UART_TX_PARITY_EN
- Defined: a PARITY state is inserted between DATA and STOP, transmitting an even-parity bit (XOR of the 8 data bits) for one bit period. The frame is 11 bit periods.
- Undefined: no PARITY state and no parity logic; 8N1 frame of 10 bit periods.

Test Plan:
All scenarios use CLK_FREQ=1_000_000 and UART_BPS=100_000, so BAUD_CNT_MAX=10.
1. Reset, then a single pi_flag with pi_data=8'hA5 -> tx low 2 clocks later. Sampling at bit centres gives 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop). tx_busy is high for exactly 100 clocks. fifo_cnt returns to 0.
2. Three strobes on consecutive clocks with 8'h00, 8'hFF, 8'h3C -> three back-to-back frames, 300 clocks total. No idle cycles between the STOP of one frame and the START of the next. Bytes decode in write order.
3. Burst of 20 strobes (values 0..19) at FIFO_DEPTH=16 -> the first is popped at once, so 17 bytes are sent (values 0..16), and bytes 17..19 are dropped. overflow rises on the strobe carrying value 17 and stays high through the end of the test.
4. Strobe issued on the same clock as the STOP-end pop, with fifo_cnt=1 -> fifo_cnt stays 1 and no byte is lost.
5. sys_rst_n pulsed low mid-DATA of byte 8'h81 -> tx goes high immediately (asynchronously), and all outputs take their reset values. The next write of 8'h55 transmits cleanly.
6. With UART_TX_PARITY_EN defined, send 8'h07 -> parity bit=1 and frame length is 110 clocks. With 8'h03 -> parity bit=0.
